// File: rtl/election_pkg.sv
// Shared definitions for the avatar-election front end: encodings, widths
// and the 8-bit request record buffered per ballot box.
package election_pkg;

   localparam int NUM_BOXES  = 4;
   localparam int BOX_W      = 2;
   localparam int USER_ID_W  = 6;
   localparam int LOCAL_ID_W = 4;
   localparam int REQ_W      = 8;

   localparam logic [1:0] CAND_AIR   = 2'd0;
   localparam logic [1:0] CAND_FIRE  = 2'd1;
   localparam logic [1:0] CAND_WATER = 2'd2;
   localparam logic [1:0] CAND_EARTH = 2'd3;

   localparam logic [1:0] MODE_REGISTER = 2'd0;
   localparam logic [1:0] MODE_VOTE     = 2'd1;

   typedef struct packed {
      logic [1:0]            mode;
      logic [LOCAL_ID_W-1:0] local_id;
      logic [1:0]            candidate;
   } req_rec_t;

endpackage

// File: rtl/ballot_fifo.sv
// Per-box request FIFO. A push is taken only when not full at the edge, so a
// same-cycle pop never makes room for a push into a full FIFO.
module ballot_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointers are AW bits wide so they wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ballot_request_arbiter.sv
// Collects requests from four ballot boxes, buffers each box, and round-robin
// arbitrates them into one registered stream carrying userID = {box, local_id}.
module ballot_request_arbiter
   import election_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [3:0]           req_valid,
   output logic [3:0]           req_ready,
   input  logic [7:0]           req_mode,
   input  logic [15:0]          req_local_id,
   input  logic [7:0]           req_candidate,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           out_mode,
   output logic [USER_ID_W-1:0] out_userID,
   output logic [1:0]           out_candidate,
   output logic [BOX_W-1:0]     out_box,
   output logic [15:0]          grant_count
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   // Handshake: a transfer happens on any edge where valid && ready are both
   // high; the producer holds its payload stable while valid && !ready.
   logic [NUM_BOXES-1:0] full;
   logic [NUM_BOXES-1:0] empty;
   logic [NUM_BOXES-1:0] pop;
   logic [REQ_W-1:0]     head  [NUM_BOXES];
   logic [CNT_W-1:0]     count [NUM_BOXES];
   logic [BOX_W-1:0]     rr_ptr;
   logic [BOX_W-1:0]     grant_idx;
   logic                 grant_found;
   logic                 load_en;
   req_rec_t             granted;
   logic                 unused_count;

   for (genvar b = 0; b < NUM_BOXES; b++) begin : g_box
      req_rec_t rec;
      assign rec = '{mode: req_mode[2*b +: 2], local_id: req_local_id[4*b +: 4],
                     candidate: req_candidate[2*b +: 2]};
      ballot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk       (CLK),
         .rst_n     (RST_N),
         .push      (req_valid[b]),
         .push_data (rec),
         .pop       (pop[b]),
         .head      (head[b]),
         .full      (full[b]),
         .empty     (empty[b]),
         .count     (count[b])
      );
   end

   assign req_ready    = ~full;
   assign unused_count = ^{count[0], count[1], count[2], count[3]};
   assign load_en      = !out_valid || out_ready;

   // Scan from the farthest offset down so the first non-empty box after rr_ptr wins.
   always_comb begin
      logic [BOX_W-1:0] idx;
      idx         = rr_ptr;
      grant_found = 1'b0;
      grant_idx   = rr_ptr;
      for (int i = NUM_BOXES - 1; i >= 0; i--) begin
         idx = rr_ptr + BOX_W'(i);
         if (!empty[idx]) begin
            grant_found = 1'b1;
            grant_idx   = idx;
         end
      end
   end

   assign pop     = (load_en && grant_found) ? (4'b0001 << grant_idx) : 4'b0000;
   assign granted = head[grant_idx];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_valid     <= 1'b0;
         out_mode      <= '0;
         out_userID    <= '0;
         out_candidate <= '0;
         out_box       <= '0;
         rr_ptr        <= '0;
      end else if (load_en) begin
         out_valid <= grant_found;
         if (grant_found) begin
            out_mode      <= granted.mode;
            out_userID    <= {grant_idx, granted.local_id};
            out_candidate <= granted.candidate;
            out_box       <= grant_idx;
            rr_ptr        <= grant_idx + BOX_W'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         grant_count <= '0;
      end else if (out_valid && out_ready) begin
         for (int b = 0; b < NUM_BOXES; b++) begin
            if (out_box == BOX_W'(b) && grant_count[4*b +: 4] != 4'hF)
               grant_count[4*b +: 4] <= grant_count[4*b +: 4] + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_ballot_request_arbiter.sv
// Directed bench for ballot_request_arbiter: scoreboard of expected output
// records plus a saturating grant-count model, checked with immediate asserts.
module tb_ballot_request_arbiter;
   import election_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [7:0]  req_mode;
   logic [15:0] req_local_id;
   logic [7:0]  req_candidate;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_mode;
   logic [5:0]  out_userID;
   logic [1:0]  out_candidate;
   logic [1:0]  out_box;
   logic [15:0] grant_count;

   int          vectors = 0;
   int          miscompares = 0;
   logic [11:0] exp_q[$];
   int          gc_model[4];

   ballot_request_arbiter #(.FIFO_DEPTH(4)) dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_mode      (req_mode),
      .req_local_id  (req_local_id),
      .req_candidate (req_candidate),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_mode      (out_mode),
      .out_userID    (out_userID),
      .out_candidate (out_candidate),
      .out_box       (out_box),
      .grant_count   (grant_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected record layout: {mode, userID, candidate, box}
   function automatic logic [11:0] mk(input int b, input logic [1:0] m,
                                      input logic [3:0] l, input logic [1:0] c);
      logic [1:0] bx;
      bx = 2'(b);
      return {m, bx, l, c, bx};
   endfunction

   function automatic logic [15:0] gc_exp();
      return {4'(gc_model[3]), 4'(gc_model[2]), 4'(gc_model[1]), 4'(gc_model[0])};
   endfunction

   task automatic set_req(input int b, input logic [1:0] m, input logic [3:0] l,
                          input logic [1:0] c);
      req_valid[b]          = 1'b1;
      req_mode[2*b +: 2]    = m;
      req_local_id[4*b +: 4] = l;
      req_candidate[2*b +: 2] = c;
   endtask

   task automatic clr_req();
      req_valid     = '0;
      req_mode      = '0;
      req_local_id  = '0;
      req_candidate = '0;
   endtask

   // Score a transfer happening at the coming edge, then advance one cycle.
   task automatic tick();
      logic [11:0] e;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL unexpected_out observed=%h expected=none",
                   {out_mode, out_userID, out_candidate, out_box});
         end else begin
            e = exp_q.pop_front();
            check("out_data", {4'h0, out_mode, out_userID, out_candidate, out_box}, {4'h0, e});
            if (gc_model[e[1:0]] < 15) gc_model[e[1:0]]++;
         end
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int sent;
      int cyc;
      logic [1:0] m;
      logic [1:0] c;
      clr_req();
      out_ready = 1'b0;
      for (int b = 0; b < 4; b++) gc_model[b] = 0;

      // Power-on reset state
      repeat (2) @(posedge CLK);
      #1;
      check("rst_valid", {15'h0, out_valid}, 16'h0);
      check("rst_ready", {12'h0, req_ready}, 16'h000F);
      check("rst_gc", grant_count, 16'h0);
      check("rst_fields", {6'h0, out_mode, out_userID, out_candidate, out_box}, 16'h0);
      RST_N = 1'b1;

      // Buffer requests behind a stalled output, then reset mid-stream
      for (int i = 0; i < 4; i++) begin
         set_req(1, MODE_VOTE, 4'(i), CAND_FIRE);
         tick();
      end
      clr_req();
      check("prefill_valid", {15'h0, out_valid}, 16'h1);
      RST_N = 1'b0;
      #1;
      check("midrst_valid", {15'h0, out_valid}, 16'h0);
      check("midrst_ready", {12'h0, req_ready}, 16'h000F);
      check("midrst_gc", grant_count, 16'h0);
      check("midrst_uid", {10'h0, out_userID}, 16'h0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;

      // Round-robin: all four boxes push together
      out_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         set_req(b, 2'(b), 4'(4'hA + b), 2'(3 - b));
         exp_q.push_back(mk(b, 2'(b), 4'(4'hA + b), 2'(3 - b)));
      end
      tick();
      clr_req();
      check("rr_latency", {15'h0, out_valid}, 16'h0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("rr_valid", {15'h0, out_valid}, 16'h1);
         check("rr_box", {14'h0, out_box}, 16'(k));
      end
      tick();
      check("rr_idle", {15'h0, out_valid}, 16'h0);
      check("rr_gc", grant_count, 16'h1111);

      // Single request from box 2
      set_req(2, MODE_REGISTER, 4'h5, CAND_FIRE);
      exp_q.push_back(mk(2, MODE_REGISTER, 4'h5, CAND_FIRE));
      tick();
      clr_req();
      check("single_latency", {15'h0, out_valid}, 16'h0);
      tick();
      check("single_valid", {15'h0, out_valid}, 16'h1);
      check("single_uid", {10'h0, out_userID}, 16'h0025);
      check("single_box", {14'h0, out_box}, 16'h2);
      check("single_mode", {14'h0, out_mode}, 16'h0);
      check("single_cand", {14'h0, out_candidate}, 16'h1);
      tick();

      // Grant box 0 so the pointer lands on 1, then only box 3 is non-empty
      set_req(0, MODE_VOTE, 4'h7, CAND_AIR);
      exp_q.push_back(mk(0, MODE_VOTE, 4'h7, CAND_AIR));
      tick();
      clr_req();
      tick();
      tick();
      set_req(3, MODE_VOTE, 4'h9, CAND_EARTH);
      exp_q.push_back(mk(3, MODE_VOTE, 4'h9, CAND_EARTH));
      tick();
      clr_req();
      tick();
      check("skip_valid", {15'h0, out_valid}, 16'h1);
      check("skip_box", {14'h0, out_box}, 16'h3);
      tick();
      // Pointer is now 0: box 1 must win over box 3
      set_req(1, MODE_REGISTER, 4'h1, CAND_WATER);
      set_req(3, MODE_VOTE, 4'h2, CAND_FIRE);
      exp_q.push_back(mk(1, MODE_REGISTER, 4'h1, CAND_WATER));
      exp_q.push_back(mk(3, MODE_VOTE, 4'h2, CAND_FIRE));
      tick();
      clr_req();
      tick();
      check("ptr_box_a", {14'h0, out_box}, 16'h1);
      tick();
      check("ptr_valid_b", {15'h0, out_valid}, 16'h1);
      check("ptr_box_b", {14'h0, out_box}, 16'h3);
      tick();
      check("ptr_idle", {15'h0, out_valid}, 16'h0);

      // Backpressure: six pushes into box 1 with output stalled
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         m = 2'($urandom_range(0, 3));
         c = 2'($urandom_range(0, 3));
         set_req(1, m, 4'(i + 3), c);
         check("bp_ready", {15'h0, req_ready[1]}, (i < 5) ? 16'h1 : 16'h0);
         if (i < 5) exp_q.push_back(mk(1, m, 4'(i + 3), c));
         tick();
      end
      clr_req();
      check("bp_hold_valid", {15'h0, out_valid}, 16'h1);
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check("bp_drain_valid", {15'h0, out_valid}, 16'h1);
         tick();
      end
      check("bp_idle", {15'h0, out_valid}, 16'h0);
      check("bp_ready_back", {12'h0, req_ready}, 16'h000F);
      check("bp_gc", grant_count, gc_exp());

      // Saturation and pointer wrap: 20 requests from box 0 under random stalls
      sent = 0;
      cyc = 0;
      while ((sent < 20 || exp_q.size() != 0) && cyc < 400) begin
         out_ready = (sent < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
         clr_req();
         if (sent < 20 && req_ready[0]) begin
            m = 2'($urandom_range(0, 3));
            c = 2'($urandom_range(0, 3));
            set_req(0, m, 4'(sent), c);
            exp_q.push_back(mk(0, m, 4'(sent), c));
            sent++;
         end
         tick();
         cyc++;
      end
      clr_req();
      check("sat_sent", 16'(sent), 16'd20);
      check("sat_drained", 16'(exp_q.size()), 16'h0);
      check("sat_gc0", {12'h0, grant_count[3:0]}, 16'h000F);
      check("sat_gc", grant_count, gc_exp());
      check("sat_idle", {15'h0, out_valid}, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
